// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response bundle for mem_access_ctrl.
// master: the CPU datapath issuing requests; slave: the controller.
interface mem_access_ctrl_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences single-beat CPU requests into timed memory
// cycles (setup, fixed-width en pulse, hold/recover) for the 128x8 memory.
// Every mem_*/rsp_* output is a flop loaded from a decode of the current
// FSM state, so the memory pins lag the FSM by exactly one cycle and no
// combinational path exists from req_* to mem_*.
// Optional feature: define MEM_CTRL_WPROT_EN to turn writes to addresses
// 0..WPROT_TOP into dummy cycles flagged by wprot_err.
module mem_access_ctrl #(
  parameter int ADDR_WIDTH    = 7,
  parameter int DATA_WIDTH    = 8,
  parameter int SETUP_CYCLES  = 1,
  parameter int ACCESS_CYCLES = 3
`ifdef MEM_CTRL_WPROT_EN
  , parameter int WPROT_TOP   = 15
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_access_ctrl_if.slave      bus,
  output logic                  mem_en,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_input_data,
  input  logic [DATA_WIDTH-1:0] mem_output_data
`ifdef MEM_CTRL_WPROT_EN
  , output logic                wprot_err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RECOVER
  } state_t;

  localparam logic [3:0] LP_SETUP_LAST  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] LP_ACCESS_LAST = 4'(ACCESS_CYCLES - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_next;
  logic                  w_accept;
  logic                  w_blocked;

  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  r_mem_en;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [DATA_WIDTH-1:0] r_mem_input_data;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  logic                  w_mem_en_next;
  logic                  w_mem_read_next;
  logic                  w_mem_write_next;
  logic                  w_rsp_valid_next;
  logic                  w_addr_load;
  logic                  w_capture;

  assign w_accept      = bus.req_valid && (r_state == ST_IDLE);
  assign bus.req_ready = (r_state == ST_IDLE);

`ifdef MEM_CTRL_WPROT_EN
  localparam logic [ADDR_WIDTH-1:0] LP_WPROT_TOP = ADDR_WIDTH'(WPROT_TOP);

  logic r_blocked;
  logic r_wprot_err;

  // Flag protected writes at acceptance; report the flag with the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blocked   <= 1'b0;
      r_wprot_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_blocked <= bus.req_write && (bus.req_addr <= LP_WPROT_TOP);
      end
      r_wprot_err <= (r_state == ST_RECOVER) && r_blocked;
    end
  end

  assign w_blocked = r_blocked;
  assign wprot_err = r_wprot_err;
`else
  assign w_blocked = 1'b0;
`endif

  // FSM state and phase counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next state, counter and the decoded values for the output flops.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_mem_en_next    = 1'b0;
    w_mem_read_next  = 1'b0;
    w_mem_write_next = 1'b0;
    w_rsp_valid_next = 1'b0;
    w_addr_load      = 1'b0;
    w_capture        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_SETUP;
          w_cnt_next   = LP_SETUP_LAST;
        end
      end
      ST_SETUP: begin
        w_mem_read_next  = !r_write;
        w_mem_write_next = r_write && !w_blocked;
        w_addr_load      = 1'b1;
        if (r_cnt == 4'd0) begin
          w_state_next = ST_ACCESS;
          w_cnt_next   = LP_ACCESS_LAST;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_ACCESS: begin
        w_mem_read_next  = !r_write;
        w_mem_write_next = r_write && !w_blocked;
        w_mem_en_next    = !w_blocked;
        if (r_cnt == 4'd0) begin
          w_state_next = ST_RECOVER;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_RECOVER: begin
        // The flops still show the last en cycle here, so this edge is the
        // one that closes the pulse: sample read data now.
        w_mem_read_next  = !r_write;
        w_mem_write_next = r_write && !w_blocked;
        w_rsp_valid_next = 1'b1;
        w_capture        = !r_write;
        w_state_next     = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Latch the request on acceptance; the requester may change it afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_write <= bus.req_write;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
    end
  end

  // Registered memory pins and response; address/data only move in setup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_en         <= 1'b0;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
      r_mem_address    <= '0;
      r_mem_input_data <= '0;
      r_rsp_valid      <= 1'b0;
      r_rsp_rdata      <= '0;
    end else begin
      r_mem_en    <= w_mem_en_next;
      r_mem_read  <= w_mem_read_next;
      r_mem_write <= w_mem_write_next;
      r_rsp_valid <= w_rsp_valid_next;
      if (w_addr_load) begin
        r_mem_address    <= r_addr;
        r_mem_input_data <= r_wdata;
      end
      if (w_capture) begin
        r_rsp_rdata <= mem_output_data;
      end
    end
  end

  assign mem_en         = r_mem_en;
  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign mem_address    = r_mem_address;
  assign mem_input_data = r_mem_input_data;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_rdata  = r_rsp_rdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: default DUT on a behavioural 128x8 memory,
// plus a second DUT with SETUP_CYCLES=2 / ACCESS_CYCLES=1 on a fixed
// address-derived read pattern. Honours MEM_CTRL_WPROT_EN when defined.
module tb_mem_access_ctrl;

  logic clk;
  logic rst_n;

  mem_access_ctrl_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) bus ();
  mem_access_ctrl_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) bus2 ();

  logic       mem_en, mem_read, mem_write;
  logic [6:0] mem_address;
  logic [7:0] mem_input_data, mem_output_data;

  logic       mem2_en, mem2_read, mem2_write;
  logic [6:0] mem2_address;
  logic [7:0] mem2_input_data, mem2_output_data;

`ifdef MEM_CTRL_WPROT_EN
  logic wprot_err1, wprot_err2;
`endif

  mem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .mem_en(mem_en), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_input_data(mem_input_data),
    .mem_output_data(mem_output_data)
`ifdef MEM_CTRL_WPROT_EN
    , .wprot_err(wprot_err1)
`endif
  );

  mem_access_ctrl #(.SETUP_CYCLES(2), .ACCESS_CYCLES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2),
    .mem_en(mem2_en), .mem_read(mem2_read), .mem_write(mem2_write),
    .mem_address(mem2_address), .mem_input_data(mem2_input_data),
    .mem_output_data(mem2_output_data)
`ifdef MEM_CTRL_WPROT_EN
    , .wprot_err(wprot_err2)
`endif
  );

  // Behavioural memory with a backdoor preload port.
  logic [7:0] mem_array [128];
  logic       bd_we;
  logic [6:0] bd_addr;
  logic [7:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) mem_array[bd_addr] <= bd_data;
    else if (mem_en && mem_write) mem_array[mem_address] <= mem_input_data;
  end
  assign mem_output_data  = mem_array[mem_address];
  assign mem2_output_data = {1'b0, mem2_address} ^ 8'h5A;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One request on the default DUT; traces are bit k = sample after edge k.
  task automatic run_txn(input string tag, input logic w, input logic [6:0] a,
                         input logic [7:0] d, input logic [7:0] exp_rd, input logic exp_err);
    logic [6:0] en_t, rd_t, wr_t, rv_t, rdy_t, er_t;
    logic       addr_ok;
    logic [7:0] rd_at_rsp;
    int         waited;
    en_t = '0; rd_t = '0; wr_t = '0; rv_t = '0; rdy_t = '0; er_t = '0;
    addr_ok = 1'b1; rd_at_rsp = '0; waited = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("%s accept", tag), 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) bus.req_valid = 1'b0;
      en_t[k] = mem_en; rd_t[k] = mem_read; wr_t[k] = mem_write;
      rv_t[k] = bus.rsp_valid; rdy_t[k] = bus.req_ready;
`ifdef MEM_CTRL_WPROT_EN
      er_t[k] = wprot_err1;
`endif
      if (k >= 1 && k <= 5) begin
        if (mem_address !== a || (w && mem_input_data !== d)) addr_ok = 1'b0;
      end
      if (k == 5) rd_at_rsp = bus.rsp_rdata;
    end
    check($sformatf("%s en_trace", tag), 32'(en_t), exp_err ? 32'h0 : 32'b0011100);
    check($sformatf("%s rd_trace", tag), 32'(rd_t), w ? 32'h0 : 32'b0111110);
    check($sformatf("%s wr_trace", tag), 32'(wr_t), (w && !exp_err) ? 32'b0111110 : 32'h0);
    check($sformatf("%s rsp_trace", tag), 32'(rv_t), 32'b0100000);
    check($sformatf("%s ready_trace", tag), 32'(rdy_t), 32'b1100000);
    check($sformatf("%s addr_stable", tag), 32'(addr_ok), 32'd1);
    check($sformatf("%s rdata", tag), 32'(rd_at_rsp), 32'(exp_rd));
`ifdef MEM_CTRL_WPROT_EN
    check($sformatf("%s wprot_trace", tag), 32'(er_t), exp_err ? 32'b0100000 : 32'h0);
`else
    check($sformatf("%s wprot_trace", tag), 32'(er_t), 32'h0);
`endif
    $display("txn %s %s addr=%02h wdata=%02h rdata=%02h en=%07b rsp=%07b",
             tag, w ? "WR" : "RD", a, d, rd_at_rsp, en_t, rv_t);
  endtask

  typedef struct {
    logic       w;
    logic [6:0] a;
    logic [7:0] d;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] acc_mask, rsp_mask, rdy_mask;
    logic [7:0]  b2b_rd, rd_after_abort;
    logic        saw_rsp, accepted;
    logic [5:0]  en2_t, rd2_t, wr2_t, rv2_t, rdy2_t;
    logic [7:0]  rd2_val;
    logic        data2_ok;
    int          idx, waited;
    logic        sw [3];
    logic [6:0]  sa [3];
    logic [7:0]  sd [3];

`ifdef MEM_CTRL_WPROT_EN
    vecs[0] = '{1'b1, 7'h01, 8'hFF, 8'hA5, 1'b1};
    vecs[1] = '{1'b0, 7'h01, 8'h00, 8'h11, 1'b0};
    vecs[2] = '{1'b1, 7'h7F, 8'hA5, 8'h11, 1'b0};
    vecs[3] = '{1'b0, 7'h7F, 8'h00, 8'hA5, 1'b0};
    vecs[4] = '{1'b1, 7'h00, 8'h00, 8'hA5, 1'b1};
    vecs[5] = '{1'b0, 7'h00, 8'h00, 8'h77, 1'b0};
    vecs[6] = '{1'b1, 7'h05, 8'h55, 8'h77, 1'b1};
    vecs[7] = '{1'b0, 7'h05, 8'h00, 8'h3C, 1'b0};
    vecs[8] = '{1'b1, 7'h10, 8'h66, 8'h3C, 1'b0};
    vecs[9] = '{1'b0, 7'h10, 8'h00, 8'h66, 1'b0};
    rd_after_abort = 8'h11;
`else
    vecs[0] = '{1'b1, 7'h01, 8'hFF, 8'hA5, 1'b0};
    vecs[1] = '{1'b0, 7'h01, 8'h00, 8'hFF, 1'b0};
    vecs[2] = '{1'b1, 7'h7F, 8'hA5, 8'hFF, 1'b0};
    vecs[3] = '{1'b0, 7'h7F, 8'h00, 8'hA5, 1'b0};
    vecs[4] = '{1'b1, 7'h00, 8'h00, 8'hA5, 1'b0};
    vecs[5] = '{1'b0, 7'h00, 8'h00, 8'h00, 1'b0};
    vecs[6] = '{1'b1, 7'h05, 8'h55, 8'h00, 1'b0};
    vecs[7] = '{1'b0, 7'h05, 8'h00, 8'h55, 1'b0};
    vecs[8] = '{1'b1, 7'h10, 8'h66, 8'h55, 1'b0};
    vecs[9] = '{1'b0, 7'h10, 8'h00, 8'h66, 1'b0};
    rd_after_abort = 8'hFF;
`endif

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;

    // Reset state.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset_outputs",
          32'({bus.req_ready, mem_en, mem_read, mem_write, bus.rsp_valid, bus.rsp_rdata}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}));
    $display("txn reset ready=%0b en=%0b rsp=%0b", bus.req_ready, mem_en, bus.rsp_valid);

    // Backdoor preload while in reset.
    sa[0] = 7'h01; sd[0] = 8'h11;
    sa[1] = 7'h05; sd[1] = 8'h3C;
    sa[2] = 7'h7F; sd[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bd_we = 1'b1; bd_addr = sa[i]; bd_data = sd[i];
    end
    @(negedge clk); bd_we = 1'b1; bd_addr = 7'h00; bd_data = 8'h77;
    @(negedge clk); bd_we = 1'b1; bd_addr = 7'h10; bd_data = 8'h10;
    @(negedge clk); bd_we = 1'b0;
    rst_n = 1'b1;

    // Back-to-back with req_valid held high across three requests.
    sw[0] = 1'b1; sa[0] = 7'h7F; sd[0] = 8'hA5;
    sw[1] = 1'b0; sa[1] = 7'h7F; sd[1] = 8'h00;
    sw[2] = 1'b1; sa[2] = 7'h00; sd[2] = 8'h00;
    acc_mask = '0; rsp_mask = '0; rdy_mask = '0; b2b_rd = '0; idx = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = sw[0]; bus.req_addr = sa[0]; bus.req_wdata = sd[0];
    for (int c = 0; c < 18; c++) begin
      rdy_mask[c] = bus.req_ready;
      accepted = bus.req_ready && bus.req_valid;
      acc_mask[c] = accepted;
      @(posedge clk);
      #1;
      if (accepted) begin
        idx++;
        if (idx < 3) begin
          bus.req_write = sw[idx]; bus.req_addr = sa[idx]; bus.req_wdata = sd[idx];
        end else begin
          bus.req_valid = 1'b0;
        end
      end
      @(negedge clk);
      if (bus.rsp_valid) begin
        rsp_mask[c] = 1'b1;
        if (c == 11) b2b_rd = bus.rsp_rdata;
      end
    end
    check("b2b accept_cycles", 32'(acc_mask), 32'h01041);
    check("b2b rsp_cycles", 32'(rsp_mask), 32'h20820);
    check("b2b ready_cycles", 32'(rdy_mask), 32'h01041);
    check("b2b read_data", 32'(b2b_rd), 32'h000000A5);
    $display("txn b2b accepts=%05h rsps=%05h rdata=%02h", acc_mask, rsp_mask, b2b_rd);

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].d,
              vecs[i].exp_rd, vecs[i].exp_err);
    end

    // Reset in the second en cycle of a write.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 7'h22; bus.req_wdata = 8'h99;
    waited = 0;
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("abort en_before", 32'(mem_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort en_async_drop", 32'(mem_en), 32'd0);
    check("abort ready_in_reset", 32'(bus.req_ready), 32'd1);
    saw_rsp = 1'b0;
    repeat (2) begin
      @(negedge clk);
      saw_rsp = saw_rsp | bus.rsp_valid;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      saw_rsp = saw_rsp | bus.rsp_valid;
    end
    check("abort no_rsp", 32'(saw_rsp), 32'd0);
    check("abort ready_after", 32'(bus.req_ready), 32'd1);
    check("abort rdata_cleared", 32'(bus.rsp_rdata), 32'd0);
    $display("txn abort rsp_seen=%0b ready=%0b", saw_rsp, bus.req_ready);
    run_txn("post_abort", 1'b0, 7'h01, 8'h00, rd_after_abort, 1'b0);

    // Second DUT: SETUP_CYCLES=2, ACCESS_CYCLES=1.
    en2_t = '0; rd2_t = '0; wr2_t = '0; rv2_t = '0; rdy2_t = '0; rd2_val = '0; data2_ok = 1'b1;
    @(negedge clk);
    bus2.req_valid = 1'b1; bus2.req_write = 1'b0; bus2.req_addr = 7'h33; bus2.req_wdata = 8'hC3;
    check("cfg2 ready_idle", 32'(bus2.req_ready), 32'd1);
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) bus2.req_valid = 1'b0;
      en2_t[k] = mem2_en; rd2_t[k] = mem2_read; wr2_t[k] = mem2_write;
      rv2_t[k] = bus2.rsp_valid; rdy2_t[k] = bus2.req_ready;
      if (k >= 1 && k <= 4 && (mem2_address !== 7'h33 || mem2_input_data !== 8'hC3))
        data2_ok = 1'b0;
      if (k == 4) rd2_val = bus2.rsp_rdata;
    end
    check("cfg2 en_trace", 32'(en2_t), 32'b001000);
    check("cfg2 rd_trace", 32'(rd2_t), 32'b011110);
    check("cfg2 wr_trace", 32'(wr2_t), 32'b000000);
    check("cfg2 rsp_trace", 32'(rv2_t), 32'b010000);
    check("cfg2 ready_trace", 32'(rdy2_t), 32'b110000);
    check("cfg2 addr_stable", 32'(data2_ok), 32'd1);
    check("cfg2 rdata", 32'(rd2_val), 32'h00000069);
    $display("txn cfg2 RD addr=33 rdata=%02h en=%06b rsp=%06b", rd2_val, en2_t, rv2_t);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Clocked sequencer directly upstream of the 128x8 `memory` block.
- Accepts single-beat read/write requests from the CPU datapath over a valid/ready handshake.
- Converts each request into a correctly timed memory cycle: command/address setup, an `en` pulse of fixed width, then a hold cycle.
- Returns read data with a one-cycle response strobe; decouples the CPU clock domain logic from the memory's level-sensitive `en`/`read`/`write` interface.

Parameters:
- ADDR_WIDTH, 7, memory address width.
- DATA_WIDTH, 8, data word width.
- SETUP_CYCLES, 1, cycles command/address/data are driven with `mem_en` low before the pulse (legal range 1..15).
- ACCESS_CYCLES, 3, width of the `mem_en` pulse in cycles (legal range 1..15).
- WPROT_TOP, 15, highest protected address; used only with MEM_CTRL_WPROT_EN.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  request address.
- req_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  one-cycle completion strobe.
- rsp_rdata  output  DATA_WIDTH  read data, valid when rsp_valid follows a read.
- mem_en  output  1  to memory `en`.
- mem_read  output  1  to memory `read`.
- mem_write  output  1  to memory `write`.
- mem_address  output  ADDR_WIDTH  to memory `address`.
- mem_input_data  output  DATA_WIDTH  to memory `input_data`.
- mem_output_data  input  DATA_WIDTH  from memory `output_data`.
- wprot_err  output  1  present only with MEM_CTRL_WPROT_EN.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE. Counter is cleared.
  - All outputs are 0, except req_ready, which is 1.
  - The reset takes effect immediately, mid-operation included: `mem_en` drops at once and no rsp_valid is issued for the aborted request.
- All mem_* and rsp_* outputs are registered; no combinational path from req_* to mem_*.
- FSM states: IDLE, SETUP, ACCESS, RECOVER.
- IDLE:
  - req_ready=1; mem_en=0, mem_read=0, mem_write=0.
  - mem_address and mem_input_data hold their last values.
  - On req_valid: latch req_write/req_addr/req_wdata, then go to SETUP with counter=SETUP_CYCLES-1.
- SETUP:
  - req_ready=0.
  - mem_read = ~write, mem_write = write, address/data driven from the latched request; mem_en=0.
  - Counter decrements each cycle; at 0 go to ACCESS with counter=ACCESS_CYCLES-1.
- ACCESS:
  - mem_en=1; command, address and data are unchanged.
  - Counter decrements each cycle; at 0 go to RECOVER.
  - On the last ACCESS cycle of a read, capture mem_output_data into rsp_rdata at the clock edge.
- RECOVER (1 cycle):
  - mem_en=0; mem_read/mem_write are still held (hold time).
  - rsp_valid=1 for this cycle only.
  - Then go to IDLE: mem_read and mem_write return to 0 and req_ready returns to 1.
- Latency: rsp_valid is high exactly SETUP_CYCLES+ACCESS_CYCLES+1 cycles after the accepting edge; the default is 5.
- Throughput: the minimum request-to-request spacing is SETUP_CYCLES+ACCESS_CYCLES+2 cycles; the default is 6.
- Invariants:
  - mem_read and mem_write are never both 1.
  - mem_address and mem_input_data never change while mem_en=1.
  - mem_en is never high outside ACCESS.
- req_valid while busy: ignored (req_ready=0); the requester holds its request until accepted.
- Writes leave rsp_rdata unchanged.
- Back-to-back: a request present in the IDLE cycle after RECOVER is accepted immediately.
- Address is passed through unmodified; no wrap-around logic. The full 0..2^ADDR_WIDTH-1 range is legal.

Optional Feature:
- MEM_CTRL_WPROT_EN defined:
  - A write with req_addr <= WPROT_TOP is accepted but runs as a dummy cycle: mem_write=0, mem_read=0, mem_en stays 0 throughout.
  - rsp_valid still asserts at the normal latency, with wprot_err=1 in the same cycle.
  - Reads are unaffected.
- MEM_CTRL_WPROT_EN undefined: the wprot_err port and all protection logic are absent; all writes proceed.

Test Plan:
1. Reset, then write addr=1 data=0xFF: mem_write=1 from cycle 1; mem_en=1 for exactly 3 cycles (cycles 2-4); rsp_valid is a single pulse at cycle 5; memory[1]=0xFF.
2. Read addr=1 after test 1: mem_read=1, mem_en pulse of 3 cycles; rsp_valid at +5 with rsp_rdata=0xFF; mem_write is never 1.
3. Hold req_valid high with three alternating requests (write 0xA5 to 0x7F, read 0x7F, write 0x00 to 0x00): accepted at cycles 0, 6, 12; the read returns 0xA5; req_ready=0 throughout each busy window.
4. Assert rst_n=0 during the second ACCESS cycle of a write: mem_en falls without waiting for a clock edge; no rsp_valid; after release, req_ready=1 and a new read completes normally.
5. Set SETUP_CYCLES=2, ACCESS_CYCLES=1: mem_en is a 1-cycle pulse starting 3 cycles after acceptance; rsp_valid at +4.
6. With MEM_CTRL_WPROT_EN, write 0x55 to addr 5: mem_en stays 0; rsp_valid and wprot_err both 1 at +5; a following read of addr 5 returns the old value. A write to addr 16 succeeds with wprot_err=0.
